// File: rtl/bnn_neuron_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : bnn_neuron_bank_if
// Description : Stream-in / result-out bundle for bnn_neuron_bank.
//               The master drives activations, weights, thresholds and the
//               result-side ready. The slave (the bank) drives in_ready and
//               the results.
// Revision    : 1.0 - initial release
// ============================================================================
interface bnn_neuron_bank_if #(
    parameter int PW       = 8,
    parameter int NN       = 4,
    parameter int THRESH_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [PW-1:0]          x;
    logic [NN*PW-1:0]       w;
    logic [NN*THRESH_W-1:0] threshold;
    logic                   out_valid;
    logic                   out_ready;
    logic [NN-1:0]          y;
    logic [NN*THRESH_W-1:0] popcount_out;

    modport master (
        output in_valid, in_last, x, w, threshold, out_ready,
        input  in_ready, out_valid, y, popcount_out
    );

    modport slave (
        input  in_valid, in_last, x, w, threshold, out_ready,
        output in_ready, out_valid, y, popcount_out
    );
endinterface
`default_nettype wire

// File: rtl/bnn_neuron_bank.sv
`default_nettype none
// ============================================================================
// Module      : bnn_neuron_bank
// Description : NN binary neurons sharing one streamed activation vector.
//               Stage 1 registers the per-neuron XNOR popcount of each beat.
//               Stage 2 accumulates with saturation and, on the last beat,
//               compares each sum against the threshold latched at that
//               vector's first beat.
//               Optional feature macro: BNN_NEURON_BANK_POPCOUNT_EN. When it
//               is defined, the final per-neuron sums are registered onto
//               popcount_out. When it is undefined, popcount_out is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_neuron_bank #(
    parameter int PW       = 8,
    parameter int NN       = 4,
    parameter int THRESH_W = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bnn_neuron_bank_if.slave bus
);
    localparam int c_PC_W  = $clog2(PW + 1);
    // One extra bit above the wider operand, so the raw sum can never wrap
    // before the clamp is applied.
    localparam int c_SUM_W = ((THRESH_W > c_PC_W) ? THRESH_W : c_PC_W) + 1;
    localparam logic [c_SUM_W-1:0] c_SAT =
        {{(c_SUM_W-THRESH_W){1'b0}}, {THRESH_W{1'b1}}};

    // Stage 1 state
    logic                            r_s1_valid;
    logic                            r_s1_last;
    logic                            r_s1_first;
    logic [NN-1:0][c_PC_W-1:0]       r_s1_pc;
    logic [NN*THRESH_W-1:0]          r_thr;
    logic                            r_first;

    // Stage 2 / output state
    logic [NN-1:0][THRESH_W-1:0]     r_acc;
    logic                            r_out_valid;
    logic [NN-1:0]                   r_y;

    // Combinational datapath
    logic                            w_stall;
    logic                            w_accept;
    logic                            w_s2_fire;
    logic [NN-1:0][PW-1:0]           w_match;
    logic [NN-1:0][c_PC_W-1:0]       w_pc;
    logic [NN-1:0][c_SUM_W-1:0]      w_wide;
    logic [NN-1:0][THRESH_W-1:0]     w_sum;
    logic [NN-1:0]                   w_y;

    assign w_stall      = r_out_valid && !bus.out_ready;
    assign bus.in_ready = !rst && !w_stall;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_s2_fire    = r_s1_valid && !w_stall;

    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;

    // Per-neuron XNOR popcount of the incoming beat, plus the saturating
    // sum and threshold compare for the beat held in stage 1.
    always_comb begin
        w_match = '0;
        w_pc    = '0;
        w_wide  = '0;
        w_sum   = '0;
        w_y     = '0;
        for (int n = 0; n < NN; n++) begin
            w_match[n] = ~(bus.x ^ bus.w[n*PW +: PW]);
            for (int b = 0; b < PW; b++) begin
                w_pc[n] = w_pc[n] + c_PC_W'(w_match[n][b]);
            end
            // The first beat of a vector ignores whatever the accumulator
            // holds, so no separate clear cycle is needed between vectors.
            w_wide[n] = (r_s1_first ? c_SUM_W'(0) : c_SUM_W'(r_acc[n]))
                      + c_SUM_W'(r_s1_pc[n]);
            w_sum[n]  = (w_wide[n] > c_SAT) ? {THRESH_W{1'b1}}
                                            : w_wide[n][THRESH_W-1:0];
            w_y[n]    = (w_sum[n] >= r_thr[n*THRESH_W +: THRESH_W]);
        end
    end

    // Stage 1: capture the beat's popcounts and flags. The threshold is
    // captured only on a vector's first beat. Everything holds while the
    // output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_pc    <= '0;
            r_thr      <= '0;
            r_first    <= 1'b1;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_pc    <= w_pc;
                r_s1_last  <= bus.in_last;
                r_s1_first <= r_first;
                r_first    <= bus.in_last;
                if (r_first) begin
                    r_thr <= bus.threshold;
                end
            end
        end
    end

    // Stage 2: accumulate non-last beats. A last beat clears the
    // accumulators, ready for the next vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_s2_fire) begin
            for (int n = 0; n < NN; n++) begin
                r_acc[n] <= r_s1_last ? '0 : w_sum[n];
            end
        end
    end

    // Result register: a new load takes priority over retirement, so a
    // load and a retire in the same cycle give back-to-back results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
        end else if (w_s2_fire && r_s1_last) begin
            r_out_valid <= 1'b1;
            r_y         <= w_y;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef BNN_NEURON_BANK_POPCOUNT_EN
    logic [NN*THRESH_W-1:0] r_pc_out;

    // Final per-neuron sums, loaded together with y.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_out <= '0;
        end else if (w_s2_fire && r_s1_last) begin
            r_pc_out <= w_sum;
        end
    end

    assign bus.popcount_out = r_pc_out;
`else
    assign bus.popcount_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bnn_neuron_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_neuron_bank
// Description : Directed self-checking bench for bnn_neuron_bank. The main
//               instance uses PW=8, NN=4 and THRESH_W=16. A second instance
//               with THRESH_W=4 covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bnn_neuron_bank;
`ifdef BNN_NEURON_BANK_POPCOUNT_EN
    localparam bit c_PC_EN = 1'b1;
`else
    localparam bit c_PC_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  y;
        logic [63:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    bnn_neuron_bank_if #(.PW(8), .NN(4), .THRESH_W(16)) bif ();
    bnn_neuron_bank_if #(.PW(8), .NN(4), .THRESH_W(4))  sif ();

    bnn_neuron_bank #(.PW(8), .NN(4), .THRESH_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    bnn_neuron_bank #(.PW(8), .NN(4), .THRESH_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [63:0] pcx(input logic [63:0] v);
        return c_PC_EN ? v : 64'h0;
    endfunction

    function automatic exp_t mk(input logic [3:0] yv, input logic [63:0] pcv);
        exp_t e;
        e.y  = yv;
        e.pc = pcx(pcv);
        return e;
    endfunction

    // Presents one beat from posedge+1 and returns at posedge+1 just after
    // the edge that accepts it.
    task automatic send_beat(input logic [7:0] xv, input logic [31:0] wv,
                             input logic [63:0] tv, input logic lv);
        bit done = 1'b0;
        bif.in_valid  = 1'b1;
        bif.x         = xv;
        bif.w         = wv;
        bif.threshold = tv;
        bif.in_last   = lv;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bif.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 64'(done), 64'd1);
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    // Scoreboard: every result the consumer takes must match the next
    // expected vector.
    always @(negedge clk) begin
        if (!rst && bif.out_valid && bif.out_ready) begin
            check("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_y", 64'(bif.y), 64'(e.y));
                check("result_pc", bif.popcount_out, e.pc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        bif.in_valid = 1'b0; bif.in_last = 1'b0; bif.x = '0; bif.w = '0;
        bif.threshold = '0;  bif.out_ready = 1'b1;
        sif.in_valid = 1'b0; sif.in_last = 1'b0; sif.x = '0; sif.w = '0;
        sif.threshold = '0;  sif.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bif.in_ready), 64'd0);
        check("rst_out_valid", 64'(bif.out_valid), 64'd0);
        check("rst_y", 64'(bif.y), 64'd0);
        check("rst_pc", bif.popcount_out, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bif.in_ready), 64'd1);

        // Single-beat vector with a two-edge latency check
        exp_q.push_back(mk(4'b1011, pk(8, 4, 0, 4)));
        send_beat(8'hFF, 32'hF0000FFF, pk(4, 4, 4, 4), 1'b1);
        check("lat_edge1_valid", 64'(bif.out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge2_valid", 64'(bif.out_valid), 64'd1);

        // Multi-beat vector: n0 always matches, n1 never matches
        exp_q.push_back(mk(4'b0101, pk(24, 0, 16, 8)));
        send_beat(8'hA5, 32'hFF005AA5, pk(24, 1, 16, 9), 1'b0);
        send_beat(8'h3C, 32'hFF00C33C, pk(24, 1, 16, 9), 1'b0);
        send_beat(8'h00, 32'hFF00FF00, pk(24, 1, 16, 9), 1'b1);
        repeat (3) @(posedge clk); #1;

        // Backpressure: hold a result and offer the next vector's first beat
        bif.out_ready = 1'b0;
        exp_q.push_back(mk(4'b1101, pk(8, 0, 4, 4)));
        send_beat(8'h0F, 32'h00FFF00F, pk(8, 1, 4, 4), 1'b1);
        repeat (2) @(posedge clk); #1;
        check("bp_out_valid", 64'(bif.out_valid), 64'd1);
        bif.in_valid = 1'b1; bif.x = 8'hFF; bif.w = 32'hFF00AAFF;
        bif.threshold = pk(40, 21, 0, 41); bif.in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bif.in_ready), 64'd0);
            check("bp_y_hold", 64'(bif.y), 64'b1101);
            check("bp_pc_hold", bif.popcount_out, pcx(pk(8, 0, 4, 4)));
        end
        @(posedge clk); #1;
        bif.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bif.in_ready), 64'd1);
        exp_q.push_back(mk(4'b0101, pk(40, 20, 0, 40)));
        for (int i = 0; i < 5; i++) begin
            send_beat(8'hFF, 32'hFF00AAFF, pk(40, 21, 0, 41), (i == 4));
        end
        repeat (3) @(posedge clk); #1;

        // Threshold latched at the first beat: 10, not 30
        exp_q.push_back(mk(4'b1001, pk(16, 0, 8, 16)));
        send_beat(8'hFF, 32'hFF0F00FF, pk(10, 10, 10, 10), 1'b0);
        send_beat(8'hFF, 32'hFF0F00FF, pk(30, 30, 30, 30), 1'b1);
        repeat (3) @(posedge clk); #1;

        // Back-to-back single-beat vectors, each with its own threshold
        exp_q.push_back(mk(4'b0101, pk(8, 8, 8, 8)));
        exp_q.push_back(mk(4'b1100, pk(4, 5, 6, 7)));
        send_beat(8'h00, 32'h00000000, pk(8, 9, 8, 9), 1'b1);
        send_beat(8'h00, 32'h0103070F, pk(6, 6, 6, 6), 1'b1);
        repeat (3) @(posedge clk); #1;

        // Reset in the middle of a vector drops the partial sum
        send_beat(8'hFF, 32'hFFFFFFFF, pk(0, 0, 0, 0), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 64'(bif.out_valid), 64'd0);
        exp_q.push_back(mk(4'b1111, pk(16, 16, 16, 16)));
        send_beat(8'hFF, 32'hFFFFFFFF, pk(16, 16, 16, 16), 1'b0);
        send_beat(8'hFF, 32'hFFFFFFFF, pk(16, 16, 16, 16), 1'b1);
        repeat (4) @(posedge clk); #1;
        check("all_results_seen", 64'(exp_q.size()), 64'd0);

        // Saturation: THRESH_W=4, three full-match beats clamp at 15
        begin
            bit seen = 1'b0;
            sif.in_valid = 1'b1; sif.x = 8'hFF; sif.w = 32'hFFFFFFFF;
            sif.threshold = 16'hFFFF;
            for (int i = 0; i < 3; i++) begin
                sif.in_last = (i == 2);
                @(negedge clk);
                check("sat_in_ready", 64'(sif.in_ready), 64'd1);
                @(posedge clk); #1;
            end
            sif.in_valid = 1'b0; sif.in_last = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (sif.out_valid) begin
                    seen = 1'b1;
                    check("sat_y", 64'(sif.y), 64'b1111);
                    check("sat_pc", 64'(sif.popcount_out), c_PC_EN ? 64'hFFFF : 64'h0);
                end
            end
            check("sat_result_seen", 64'(seen), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
